// File: rtl/reaction_timer_pkg.sv
// Shared types and helpers for the reaction-time leaderboard.
// Holds the FSM state enum, BCD digit width and width helpers.
package reaction_timer_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        SHIFT,
        FINISH
    } lb_state_t;

    function automatic int rank_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // True when every one of the low n_digits nibbles is 0..9.
    function automatic logic is_valid_bcd(
        input logic [63:0] score,
        input int          n_digits
    );
        logic ok;
        ok = 1'b1;
        for (int d = 0; d < 16; d++) begin
            if (d < n_digits && score[d*BCD_W +: BCD_W] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/reaction_leaderboard_if.sv
// Submit handshake and insertion result bundle of the leaderboard.
// The client drives the master side, the table sits on the slave side.
interface reaction_leaderboard_if #(
    parameter int N_DIGITS = 4,
    parameter int DEPTH    = 4
);
    import reaction_timer_pkg::*;

    localparam int SW     = BCD_W * N_DIGITS;
    localparam int RANK_W = rank_width(DEPTH);

    logic              submit_valid;
    logic              submit_ready;
    logic [SW-1:0]     submit_score;
    logic              done;
    logic [RANK_W-1:0] done_rank;
    logic              new_record;
    logic              reject;

    modport master (
        output submit_valid,
        output submit_score,
        input  submit_ready,
        input  done,
        input  done_rank,
        input  new_record,
        input  reject
    );

    modport slave (
        input  submit_valid,
        input  submit_score,
        output submit_ready,
        output done,
        output done_rank,
        output new_record,
        output reject
    );

endinterface

// File: rtl/bcd_score_lt.sv
// Candidate-beats-entry test for the leaderboard scan.
// An empty slot always loses to any candidate.
module bcd_score_lt #(
    parameter int SW = 16
) (
    input  logic [SW-1:0] cand,
    input  logic [SW-1:0] entry,
    input  logic          entry_valid,
    output logic          lt
);

    // Plain unsigned compare is monotone for well-formed BCD.
    assign lt = !entry_valid || (cand < entry);

endmodule

// File: rtl/reaction_leaderboard.sv
// Sorted top-DEPTH table of lowest BCD reaction times.
// A scan FSM finds the slot, a one-cycle shift inserts the score.
module reaction_leaderboard
    import reaction_timer_pkg::*;
#(
    parameter  int N_DIGITS = 4,
    parameter  int DEPTH    = 4,
    localparam int SW       = BCD_W * N_DIGITS,
    localparam int RANK_W   = rank_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    reaction_leaderboard_if.slave sub,
    input  logic [RANK_W-1:0]    rd_idx,
    output logic [SW-1:0]        rd_score,
    output logic                 rd_valid,
    output logic [SW-1:0]        best_score,
    output logic                 best_valid
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    lb_state_t         state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     pos;
    logic [SW-1:0]     score;
    logic [SW-1:0]     entry [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic              done_q;
    logic [RANK_W-1:0] rank_q;
    logic              record_q;
    logic              reject_q;
    logic              hit;
    logic              take;

    assign sub.submit_ready = (state == IDLE) && !clear;
    assign take = sub.submit_valid && sub.submit_ready;

    assign sub.done       = done_q;
    assign sub.done_rank  = rank_q;
    assign sub.new_record = record_q;
    assign sub.reject     = reject_q;

    assign best_score = entry[0];
    assign best_valid = valid[0];

    bcd_score_lt #(
        .SW(SW)
    ) u_lt (
        .cand        (score),
        .entry       (entry[idx]),
        .entry_valid (valid[idx]),
        .lt          (hit)
    );

    // Read port: out-of-range or empty slots read as zero.
    always_comb begin
        rd_valid = 1'b0;
        rd_score = '0;
        if (rd_idx < RANK_W'(DEPTH)) begin
            rd_valid = valid[rd_idx[IW-1:0]];
            if (rd_valid) begin
                rd_score = entry[rd_idx[IW-1:0]];
            end
        end
    end

    // Insertion FSM, table storage and registered result pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            pos      <= '0;
            score    <= '0;
            valid    <= '0;
            done_q   <= 1'b0;
            rank_q   <= '0;
            record_q <= 1'b0;
            reject_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
        end else begin
            done_q   <= 1'b0;
            rank_q   <= '0;
            record_q <= 1'b0;
            reject_q <= 1'b0;
            if (clear) begin
                state <= IDLE;
                idx   <= '0;
                valid <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    entry[i] <= '0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (take) begin
                            if (is_valid_bcd(64'(sub.submit_score),
                                             N_DIGITS)) begin
                                score <= sub.submit_score;
                                idx   <= '0;
                                state <= SCAN;
                            end else begin
                                reject_q <= 1'b1;
                            end
                        end
                    end
                    SCAN: begin
                        if (hit) begin
                            pos   <= idx;
                            state <= SHIFT;
                        end else if (idx == IW'(DEPTH - 1)) begin
                            done_q <= 1'b1;
                            rank_q <= RANK_W'(DEPTH);
                            state  <= FINISH;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                    SHIFT: begin
                        for (int i = 1; i < DEPTH; i++) begin
                            if (i > int'(pos)) begin
                                entry[i] <= entry[i-1];
                                valid[i] <= valid[i-1];
                            end
                        end
                        entry[pos] <= score;
                        valid[pos] <= 1'b1;
                        done_q     <= 1'b1;
                        rank_q     <= RANK_W'(pos);
                        record_q   <= (pos == '0);
                        state      <= FINISH;
                    end
                    FINISH: begin
                        state <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reaction_leaderboard.sv
// Directed plus random bench for reaction_leaderboard.
// A sorted-queue reference model predicts ranks, latency and table.
module tb_reaction_leaderboard;

    localparam int DEPTH    = 4;
    localparam int N_DIGITS = 4;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [2:0]  rd_idx;
    logic [15:0] rd_score;
    logic        rd_valid;
    logic [15:0] best_score;
    logic        best_valid;

    int vectors;
    int miscompares;
    int mq[$];

    reaction_leaderboard_if #(
        .N_DIGITS(N_DIGITS),
        .DEPTH(DEPTH)
    ) sub ();

    reaction_leaderboard #(
        .N_DIGITS(N_DIGITS),
        .DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .sub        (sub),
        .rd_idx     (rd_idx),
        .rd_score   (rd_score),
        .rd_valid   (rd_valid),
        .best_score (best_score),
        .best_valid (best_valid)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(
        input string       tag,
        input logic [63:0] obs,
        input logic [63:0] exp
    );
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_bcd(input int s);
        for (int d = 0; d < N_DIGITS; d++) begin
            if (((s >> (4 * d)) & 15) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Strictly-better goes ahead; equal scores queue behind.
    function automatic int model_insert(input int s);
        int p;
        p = mq.size();
        for (int i = 0; i < mq.size(); i++) begin
            if (s < mq[i]) begin
                p = i;
                break;
            end
        end
        if (p >= DEPTH) return DEPTH;
        mq.insert(p, s);
        while (mq.size() > DEPTH) void'(mq.pop_back());
        return p;
    endfunction

    task automatic check_table();
        for (int i = 0; i <= DEPTH; i++) begin
            rd_idx = 3'(i);
            #1;
            chk("rd_valid", 64'(rd_valid), 64'(i < mq.size()));
            chk("rd_score", 64'(rd_score),
                (i < mq.size()) ? 64'(mq[i]) : 64'd0);
        end
        chk("best_valid", 64'(best_valid), 64'(mq.size() > 0));
        chk("best_score", 64'(best_score),
            (mq.size() > 0) ? 64'(mq[0]) : 64'd0);
    endtask

    task automatic do_submit(
        input  logic [15:0] s,
        output int          o_cyc,
        output int          o_rank
    );
        int         exp_rank;
        int         exp_cyc;
        int         lim;
        int         got;
        int         dcnt;
        int         rcnt;
        int         rcyc;
        bit         bad;
        logic [2:0] grank;
        logic       gnr;
        bad = !model_bcd(int'(s));
        exp_rank = -1;
        exp_cyc  = -1;
        lim      = 2;
        if (!bad) begin
            exp_rank = model_insert(int'(s));
            exp_cyc  = (exp_rank < DEPTH) ? exp_rank + 3 : DEPTH + 1;
            lim      = exp_cyc + 1;
        end
        sub.submit_valid = 1'b1;
        sub.submit_score = s;
        #1;
        chk("ready_before", 64'(sub.submit_ready), 64'd1);
        @(posedge clk);
        got   = -1;
        dcnt  = 0;
        rcnt  = 0;
        rcyc  = -1;
        grank = '0;
        gnr   = 1'b0;
        for (int c = 1; c <= lim; c++) begin
            @(negedge clk);
            if (c == 1) begin
                sub.submit_valid = 1'b0;
                sub.submit_score = 16'($urandom);
            end
            #1;
            if (sub.done === 1'b1) begin
                dcnt++;
                if (got < 0) begin
                    got   = c;
                    grank = sub.done_rank;
                    gnr   = sub.new_record;
                end
            end
            if (sub.reject === 1'b1) begin
                rcnt++;
                if (rcyc < 0) rcyc = c;
            end
        end
        chk("ready_after", 64'(sub.submit_ready), 64'd1);
        if (bad) begin
            chk("reject_cycle", 64'(rcyc), 64'd1);
            chk("reject_count", 64'(rcnt), 64'd1);
            chk("done_on_reject", 64'(dcnt), 64'd0);
            o_cyc  = rcyc;
            o_rank = -1;
        end else begin
            chk("done_cycle", 64'(got), 64'(exp_cyc));
            chk("done_count", 64'(dcnt), 64'd1);
            chk("done_rank", 64'(grank), 64'(exp_rank));
            chk("new_record", 64'(gnr), 64'(exp_rank == 0));
            chk("reject_count", 64'(rcnt), 64'd0);
            o_cyc  = got;
            o_rank = int'(grank);
        end
        check_table();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        chk("ready_in_clear", 64'(sub.submit_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        #1;
        mq.delete();
        check_table();
    endtask

    initial begin
        int          cyc;
        int          rk;
        int          cnt;
        int          k;
        logic [15:0] s;

        vectors          = 0;
        miscompares      = 0;
        rst_n            = 1'b0;
        clear            = 1'b0;
        rd_idx           = '0;
        sub.submit_valid = 1'b0;
        sub.submit_score = '0;

        #25;
        chk("rst_done", 64'(sub.done), 64'd0);
        chk("rst_rank", 64'(sub.done_rank), 64'd0);
        chk("rst_record", 64'(sub.new_record), 64'd0);
        chk("rst_reject", 64'(sub.reject), 64'd0);
        check_table();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_out_of_reset", 64'(sub.submit_ready), 64'd1);

        do_submit(16'h0250, cyc, rk);
        chk("first_cycle", 64'(cyc), 64'd3);
        chk("first_rank", 64'(rk), 64'd0);
        chk("first_best", 64'(best_score), 64'h0250);

        do_submit(16'h0300, cyc, rk);
        chk("b2b_rank_a", 64'(rk), 64'd1);
        do_submit(16'h0200, cyc, rk);
        chk("b2b_rank_b", 64'(rk), 64'd0);
        do_submit(16'h0275, cyc, rk);
        chk("b2b_rank_c", 64'(rk), 64'd2);
        rd_idx = 3'd3;
        #1;
        chk("rd3_score", 64'(rd_score), 64'h0300);

        do_submit(16'h0400, cyc, rk);
        chk("full_cycle", 64'(cyc), 64'd5);
        chk("full_rank", 64'(rk), 64'd4);

        do_submit(16'h0250, cyc, rk);
        chk("tie_rank", 64'(rk), 64'd2);
        rd_idx = 3'd3;
        #1;
        chk("tie_drop", 64'(rd_score), 64'h0275);

        do_submit(16'h02A0, cyc, rk);
        chk("reject_plan_cycle", 64'(cyc), 64'd1);

        sub.submit_valid = 1'b1;
        sub.submit_score = 16'h0100;
        #1;
        chk("ready_pre_abort", 64'(sub.submit_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        sub.submit_valid = 1'b0;
        clear = 1'b1;
        #1;
        chk("ready_during_clear", 64'(sub.submit_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("ready_after_clear", 64'(sub.submit_ready), 64'd1);
        mq.delete();
        check_table();
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (sub.done === 1'b1 || sub.new_record === 1'b1) cnt++;
        end
        chk("abort_no_done", 64'(cnt), 64'd0);

        for (int n = 0; n < 250; n++) begin
            s = '0;
            k = int'($urandom_range(0, 7));
            for (int d = 0; d < N_DIGITS; d++) begin
                if (k < 4) s[4*d +: 4] = 4'($urandom_range(0, 2));
                else       s[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 9) == 0) begin
                k = int'($urandom_range(0, N_DIGITS - 1));
                s[4*k +: 4] = 4'($urandom_range(10, 15));
            end
            do_submit(s, cyc, rk);
            if ($urandom_range(0, 19) == 0) do_clear();
            k = int'($urandom_range(0, 2));
            for (int g = 0; g < k; g++) begin
                @(negedge clk);
                #1;
            end
        end

        do_clear();
        do_submit(16'h0500, cyc, rk);
        do_submit(16'h0600, cyc, rk);
        sub.submit_valid = 1'b1;
        sub.submit_score = 16'h0100;
        #1;
        chk("ready_pre_reset", 64'(sub.submit_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        sub.submit_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        mq.delete();
        chk("mid_rst_done", 64'(sub.done), 64'd0);
        chk("mid_rst_record", 64'(sub.new_record), 64'd0);
        chk("mid_rst_reject", 64'(sub.reject), 64'd0);
        check_table();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 64'(sub.submit_ready), 64'd1);
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (sub.done === 1'b1 || sub.reject === 1'b1) cnt++;
        end
        chk("rst_no_done", 64'(cnt), 64'd0);
        check_table();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
